// File: rtl/vend_pkg.sv
// Shared types and coin constants for the change dispenser.
package vend_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_PULSE    = 4'd2,
        ST_WAIT_ACK = 4'd3,
        ST_DONE     = 4'd4,
        ST_ERROR    = 4'd15
    } disp_state_t;

    localparam int unsigned Q_UNITS = 5;
    localparam int unsigned D_UNITS = 2;
    localparam int unsigned N_UNITS = 1;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    // Greedy choice: largest coin that does not exceed the amount owed.
    function automatic coin_t pick_coin(input int unsigned units);
        if (units >= Q_UNITS)      return COIN_Q;
        else if (units >= D_UNITS) return COIN_D;
        else                       return COIN_N;
    endfunction

    function automatic int unsigned coin_units(input coin_t c);
        case (c)
            COIN_Q:  return Q_UNITS;
            COIN_D:  return D_UNITS;
            default: return N_UNITS;
        endcase
    endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter shared by the eject-pulse width and the ack timeout.
module disp_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change as greedy quarter/dime/nickel eject pulses,
// waiting for the hopper's coin_seen acknowledge after each coin.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CHG_W          = 6,
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             CLK50M,
    input  logic             reset,
    input  logic             vend_req,
    input  logic [CHG_W-1:0] change_units,
    input  logic             hopper_ready,
    input  logic             coin_seen,
    input  logic             clr_err,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CHG_W-1:0] remaining,
    output logic [3:0]       led
);

    localparam int unsigned MAX_CNT = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CNT + 1);

    disp_state_t      state, state_n;
    coin_t            coin, coin_n;
    logic [CHG_W-1:0] remaining_n;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]    tmr_val;
    logic             eject_q_n, eject_d_n, eject_n_n;
    logic             busy_n, done_n, err_n;

    disp_timer #(.W(TW)) u_timer (
        .clk      (CLK50M),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_n     = state;
        coin_n      = coin;
        remaining_n = remaining;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vend_req) begin
                    remaining_n = change_units;
                    state_n     = (change_units == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                coin_n = pick_coin(32'(remaining));
                if (hopper_ready) begin
                    state_n  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_CYCLES - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_n  = ST_WAIT_ACK;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // coin_seen is checked first so it wins over a same-cycle timeout
                if (coin_seen) begin
                    remaining_n = remaining - CHG_W'(coin_units(coin));
                    state_n     = (remaining_n == '0) ? ST_DONE : ST_SELECT;
                end else if (tmr_zero) begin
                    state_n = ST_ERROR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERROR: begin
                if (clr_err) begin
                    remaining_n = '0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        eject_q_n = (state_n == ST_PULSE) && (coin_n == COIN_Q);
        eject_d_n = (state_n == ST_PULSE) && (coin_n == COIN_D);
        eject_n_n = (state_n == ST_PULSE) && (coin_n == COIN_N);
        busy_n    = state_n inside {ST_SELECT, ST_PULSE, ST_WAIT_ACK, ST_DONE};
        done_n    = (state == ST_DONE);
        err_n     = (state_n == ST_ERROR);
    end

    always_ff @(posedge CLK50M or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            coin      <= COIN_N;
            remaining <= '0;
            eject_q   <= 1'b0;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            coin      <= coin_n;
            remaining <= remaining_n;
            eject_q   <= eject_q_n;
            eject_d   <= eject_d_n;
            eject_n   <= eject_n_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    assign led = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy
// coin-count model computed with plain division.
module tb_change_dispenser;

    localparam int CHG_W   = 6;
    localparam int PULSE   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             vend_req = 1'b0;
    logic [CHG_W-1:0] change_units = '0;
    logic             hopper_ready = 1'b0;
    logic             coin_seen = 1'b0;
    logic             clr_err = 1'b0;
    logic             eject_q, eject_d, eject_n, busy, done, err;
    logic [CHG_W-1:0] remaining;
    logic [3:0]       led;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .CHG_W          (CHG_W),
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK50M       (clk),
        .reset        (reset),
        .vend_req     (vend_req),
        .change_units (change_units),
        .hopper_ready (hopper_ready),
        .coin_seen    (coin_seen),
        .clr_err      (clr_err),
        .eject_q      (eject_q),
        .eject_d      (eject_d),
        .eject_n      (eject_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .remaining    (remaining),
        .led          (led)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Full payout with a scripted hopper; expected coin list is q/d/n counts by division.
    task automatic run_payout(input string tag, input int units, input int ack_delay,
                              input int hold, input bit poke);
        int coins[$];
        int exp_rem, k, w;
        logic [2:0] lines, want;
        bit bad;
        repeat (units / 5) coins.push_back(5);
        repeat ((units % 5) / 2) coins.push_back(2);
        repeat ((units % 5) % 2) coins.push_back(1);
        exp_rem = units;

        change_units = CHG_W'(units);
        vend_req = 1'b1;
        hopper_ready = (hold == 0);
        step();
        vend_req = 1'b0;
        change_units = CHG_W'($urandom);
        checks++;
        if (busy !== 1'b1 || remaining !== CHG_W'(units)) begin
            failures++;
            $display("FAIL %s accept busy=%b remaining=%0d exp busy=1 remaining=%0d", tag, busy, remaining, units);
        end

        for (int i = 0; i < coins.size(); i++) begin
            if (i == 0 && hold > 0) begin
                bad = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    if ({eject_q, eject_d, eject_n} !== 3'b000 || led !== 4'd1) bad = 1'b1;
                    step();
                end
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s hold_quiet eject or led active during hopper hold, exp none", tag);
                end
                hopper_ready = 1'b1;
                step();
            end else begin
                k = 0;
                while ({eject_q, eject_d, eject_n} === 3'b000 && k < 200) begin
                    step();
                    k++;
                end
            end
            lines = {eject_q, eject_d, eject_n};
            want = (coins[i] == 5) ? 3'b100 : (coins[i] == 2) ? 3'b010 : 3'b001;
            checks++;
            if (lines !== want) begin
                failures++;
                $display("FAIL %s coin%0d_type got=%b exp=%b", tag, i, lines, want);
                hopper_ready = 1'b1;
                return;
            end
            w = 0;
            bad = 1'b0;
            while ({eject_q, eject_d, eject_n} !== 3'b000 && w < 100) begin
                if ({eject_q, eject_d, eject_n} !== lines) bad = 1'b1;
                w++;
                step();
            end
            checks++;
            if (w != PULSE || bad) begin
                failures++;
                $display("FAIL %s coin%0d_width got=%0d unstable=%b exp=%0d", tag, i, w, bad, PULSE);
            end
            if (poke && i == 0) begin
                vend_req = 1'b1;
                change_units = 7;
                step();
                vend_req = 1'b0;
            end
            repeat (ack_delay) step();
            coin_seen = 1'b1;
            step();
            coin_seen = 1'b0;
            exp_rem -= coins[i];
            checks++;
            if (remaining !== CHG_W'(exp_rem)) begin
                failures++;
                $display("FAIL %s coin%0d_remaining got=%0d exp=%0d", tag, i, remaining, exp_rem);
            end
        end

        k = 0;
        bad = 1'b0;
        while (done !== 1'b1 && k < 10) begin
            if ({eject_q, eject_d, eject_n} !== 3'b000) bad = 1'b1;
            step();
            k++;
        end
        checks++;
        if (done !== 1'b1 || bad) begin
            failures++;
            $display("FAIL %s done_seen done=%b extra_eject=%b exp done=1 extra_eject=0", tag, done, bad);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || remaining !== '0 || led !== 4'd0) begin
            failures++;
            $display("FAIL %s after_done done=%b busy=%b remaining=%0d led=%0d exp 0/0/0/0",
                     tag, done, busy, remaining, led);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({eject_q, eject_d, eject_n, busy, done, err} !== 6'b0 || remaining !== '0 || led !== 4'd0) begin
            failures++;
            $display("FAIL reset_state outs=%b remaining=%0d led=%0d exp all zero",
                     {eject_q, eject_d, eject_n, busy, done, err}, remaining, led);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_zero_change();
        change_units = '0;
        vend_req = 1'b1;
        step();
        vend_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || led !== 4'd4) begin
            failures++;
            $display("FAIL zero_cycle1 busy=%b done=%b led=%0d exp 1/0/4", busy, done, led);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || {eject_q, eject_d, eject_n} !== 3'b000) begin
            failures++;
            $display("FAIL zero_cycle2 busy=%b done=%b eject=%b exp 0/1/000",
                     busy, done, {eject_q, eject_d, eject_n});
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || led !== 4'd0) begin
            failures++;
            $display("FAIL zero_cycle3 done=%b err=%b led=%0d exp 0/0/0", done, err, led);
        end
    endtask

    task automatic test_jam();
        int k;
        change_units = 5;
        vend_req = 1'b1;
        hopper_ready = 1'b1;
        step();
        vend_req = 1'b0;
        k = 0;
        while (eject_q !== 1'b1 && k < 50) begin step(); k++; end
        k = 0;
        while (eject_q === 1'b1 && k < 50) begin step(); k++; end
        k = 0;
        while (err !== 1'b1 && k < TIMEOUT + 100) begin step(); k++; end
        checks++;
        if (k != TIMEOUT) begin
            failures++;
            $display("FAIL jam_latency got=%0d exp=%0d", k, TIMEOUT);
        end
        checks++;
        if (err !== 1'b1 || remaining !== 6'd5 || busy !== 1'b0 || led !== 4'd15) begin
            failures++;
            $display("FAIL jam_state err=%b remaining=%0d busy=%b led=%0d exp 1/5/0/15", err, remaining, busy, led);
        end
        vend_req = 1'b1;
        change_units = 7;
        step();
        vend_req = 1'b0;
        checks++;
        if (remaining !== 6'd5 || led !== 4'd15 || err !== 1'b1) begin
            failures++;
            $display("FAIL jam_vend_ignored remaining=%0d led=%0d err=%b exp 5/15/1", remaining, led, err);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (err !== 1'b0 || remaining !== '0 || led !== 4'd0) begin
            failures++;
            $display("FAIL jam_clear err=%b remaining=%0d led=%0d exp 0/0/0", err, remaining, led);
        end
        run_payout("after_clear", 4, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            run_payout("random", $urandom_range(1, 63), $urandom_range(0, 5), 0, 1'($urandom));
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        change_units = 10;
        vend_req = 1'b1;
        hopper_ready = 1'b1;
        step();
        vend_req = 1'b0;
        k = 0;
        while (eject_q !== 1'b1 && k < 50) begin step(); k++; end
        repeat (5) step();
        checks++;
        if (eject_q !== 1'b1) begin
            failures++;
            $display("FAIL midpulse_active eject_q=%b exp=1", eject_q);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({eject_q, eject_d, eject_n} !== 3'b000 || led !== 4'd0 || remaining !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midpulse_reset eject=%b led=%0d remaining=%0d busy=%b exp 000/0/0/0",
                     {eject_q, eject_d, eject_n}, led, remaining, busy);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_zero_change();
        run_payout("eight", 8, 2, 0, 1'b0);
        run_payout("max", 63, 1, 0, 1'b0);
        run_payout("hopper_hold", 3, 1, 50, 1'b0);
        run_payout("vend_ignored", 12, 3, 0, 1'b1);
        test_jam();
        test_random();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Responder to the vending FSM's change outputs. It accepts a change-owed request from the vending controller and pays it out as a greedy sequence of quarter, dime and nickel eject pulses to the coin hopper.
- Each coin is confirmed by the hopper's coin-seen sensor before the next coin is ejected.
- It reports busy, done and jam-error status back to the controller and to the board LEDs.

Parameters:
- CHG_W, 6, width of the change amount, in nickel units (5 cents each); max 63 units = $3.15
- PULSE_CYCLES, 16, eject-pulse high time in CLK50M cycles (≥1)
- TIMEOUT_CYCLES, 1000, cycles to wait for coin_seen after a pulse before declaring a jam (≥2)

Ports:
- CLK50M  input  1  board clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- vend_req  input  1  single-cycle request; samples change_units
- change_units  input  CHG_W  change owed, in nickel units
- hopper_ready  input  1  hopper can accept an eject pulse
- coin_seen  input  1  single-cycle pulse from the hopper exit sensor
- clr_err  input  1  clears a sticky error
- eject_q  output  1  eject one quarter (5 units)
- eject_d  output  1  eject one dime (2 units)
- eject_n  output  1  eject one nickel (1 unit)
- busy  output  1  high from acceptance until DONE or ERROR
- done  output  1  one-cycle pulse when payout is complete
- err  output  1  sticky jam flag
- remaining  output  CHG_W  units still owed
- led  output  4  state code: IDLE=0, SELECT=1, PULSE=2, WAIT_ACK=3, DONE=4, ERROR=15

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all eject outputs, busy, done and err = 0; remaining=0; counters=0.
- IDLE:
  - On vend_req=1, latch change_units into remaining and set busy=1 next cycle.
  - If change_units=0, go to DONE; otherwise go to SELECT.
- SELECT (registered coin choice):
  - coin = Q if remaining≥5; else D if remaining≥2; else N.
  - Stay in SELECT while hopper_ready=0.
  - When hopper_ready=1, go to PULSE and load the pulse counter.
- PULSE:
  - Exactly one selected eject_* line is high for exactly PULSE_CYCLES consecutive cycles; outputs are registered.
  - Then go to WAIT_ACK with the timeout counter cleared.
- WAIT_ACK:
  - On coin_seen=1: remaining -= coin value (never underflows, by construction of the greedy rule).
  - If the new remaining > 0, go to SELECT; else go to DONE.
  - If TIMEOUT_CYCLES elapse with no coin_seen, go to ERROR; remaining holds its value.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- ERROR:
  - err=1 and busy=0; remaining holds the undispensed amount for diagnosis.
  - clr_err=1 clears err and remaining, then returns to IDLE.
  - vend_req is ignored while in ERROR.
- Simultaneous / boundary events:
  - vend_req while busy: ignored; remaining is not reloaded.
  - coin_seen outside WAIT_ACK: ignored, logged as nothing.
  - coin_seen in the same cycle as the timeout expiry: coin_seen wins.
  - clr_err in DONE or IDLE: no effect.
  - Reset mid-pulse: eject lines drop asynchronously on reset assertion.
  - Maximum input 63 units → 12 Q + 1 D + 1 N = 14 coins.
- Latency for N units: 1 (accept) + per coin [≥1 SELECT + PULSE_CYCLES + ack wait] + 1 DONE.

Decomposition:
- Shared package vend_pkg:
  - state enum disp_state_t, with the encodings listed under the led port
  - coin value constants Q_UNITS=5, D_UNITS=2, N_UNITS=1
  - coin select enum coin_t {COIN_Q, COIN_D, COIN_N}
- One natural sub-module, disp_timer: a loadable down-counter reused for the pulse width and the ack timeout, with load value and zero flag.
- Everything else lives in a single FSM process plus a datapath register for remaining.

Test Plan:
- change_units=0, vend_req → no eject pulses; done high 2 cycles after the request; busy high for exactly 1 cycle.
- change_units=8 (40¢), hopper_ready=1, coin_seen 3 cycles after each pulse → eject_q, then eject_d, then eject_n, each 16 cycles wide; remaining steps 8→3→1→0; done pulses once.
- change_units=63 → 12 eject_q, 1 eject_d, 1 eject_n; final remaining=0; no extra pulses.
- change_units=5, coin_seen never arrives → err=1 after 1000 cycles; remaining=5; busy=0; clr_err → IDLE with err=0; a following vend_req is accepted normally.
- hopper_ready held low for 50 cycles in SELECT → no eject during the hold; pulse starts 1 cycle after hopper_ready rises.
- Robustness: vend_req with 7 units mid-payout is ignored; assert reset during PULSE → eject lines drop immediately, led=0, remaining=0.
